// File: rtl/sorted_vector_serializer.sv
// Buffers whole sorted vectors from the non-stallable sorting network and
// streams them one element per beat on a valid/ready port with tlast and tindex.
module sorted_vector_serializer #(
    parameter int NUMBER_WIDTH   = 10,
    parameter int NUMBERS_AMOUNT = 10,
    parameter int FIFO_DEPTH     = 4,
    parameter bit DESCENDING     = 1'b0,
    localparam int IDX_W  = (NUMBERS_AMOUNT > 1) ? $clog2(NUMBERS_AMOUNT) : 1,
    localparam int FILL_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]  data_i,
    input  logic                                         data_valid_i,
    output logic [NUMBER_WIDTH-1:0]                      tdata_o,
    output logic                                         tvalid_o,
    input  logic                                         tready_i,
    output logic                                         tlast_o,
    output logic [IDX_W-1:0]                             tindex_o,
    output logic [FILL_W-1:0]                            fill_level_o,
    output logic                                         overflow_o,
    input  logic                                         clear_overflow_i
);

    localparam int                PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0]  LAST_BEAT  = IDX_W'(NUMBERS_AMOUNT - 1);
    localparam logic [FILL_W-1:0] FULL_LEVEL = FILL_W'(FIFO_DEPTH);

    typedef logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] vector_t;

    vector_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FILL_W-1:0] fill_level;
    logic [IDX_W-1:0]  beat;
    logic              overflow;

    logic              out_valid;
    logic              at_last;
    logic              transfer;
    logic              pop;
    logic              write;
    logic [IDX_W-1:0]  elem_idx;

    // A full FIFO still accepts a vector when the same edge pops the head.
    always_comb begin
        out_valid = (fill_level != '0);
        at_last   = (beat == LAST_BEAT);
        transfer  = out_valid && tready_i;
        pop       = transfer && at_last;
        write     = data_valid_i && ((fill_level < FULL_LEVEL) || pop);
        elem_idx  = DESCENDING ? (LAST_BEAT - beat) : beat;
    end

    always_ff @(posedge clk_i) begin
        if (write) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            beat       <= '0;
        end else begin
            if (write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (transfer) begin
                beat <= at_last ? '0 : beat + 1'b1;
            end
            case ({write, pop})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
        end
    end

    // A drop on the same edge as a clear request keeps the flag set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow <= 1'b0;
        end else if (data_valid_i && !write) begin
            overflow <= 1'b1;
        end else if (clear_overflow_i) begin
            overflow <= 1'b0;
        end
    end

    assign tvalid_o     = out_valid;
    assign tlast_o      = out_valid && at_last;
    assign tindex_o     = out_valid ? elem_idx : '0;
    assign tdata_o      = out_valid ? mem[rd_ptr][elem_idx] : '0;
    assign fill_level_o = fill_level;
    assign overflow_o   = overflow;

endmodule

// File: tb/tb_sorted_vector_serializer.sv
// Drives an ascending depth-4 and a descending depth-2 serializer with the same
// inputs and compares both against a queue-based model every cycle.
module tb_sorted_vector_serializer;

    localparam int W = 8;
    localparam int N = 4;

    typedef logic [N-1:0][W-1:0] vec_t;

    logic       clk_i = 1'b0;
    logic       rst_i;
    vec_t       data_i;
    logic       data_valid_i;
    logic       tready_i;
    logic       clear_overflow_i;

    logic [W-1:0] tdata_a, tdata_d;
    logic         tvalid_a, tvalid_d;
    logic         tlast_a, tlast_d;
    logic [1:0]   tindex_a, tindex_d;
    logic [2:0]   fill_a;
    logic [1:0]   fill_d;
    logic         ovf_a, ovf_d;

    vec_t mq [2][$];
    int   beat_m [2];
    bit   ovf_m [2];

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    sorted_vector_serializer #(
        .NUMBER_WIDTH(W), .NUMBERS_AMOUNT(N), .FIFO_DEPTH(4), .DESCENDING(1'b0)
    ) u_asc (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .data_valid_i(data_valid_i),
        .tdata_o(tdata_a), .tvalid_o(tvalid_a), .tready_i(tready_i),
        .tlast_o(tlast_a), .tindex_o(tindex_a), .fill_level_o(fill_a),
        .overflow_o(ovf_a), .clear_overflow_i(clear_overflow_i)
    );

    sorted_vector_serializer #(
        .NUMBER_WIDTH(W), .NUMBERS_AMOUNT(N), .FIFO_DEPTH(2), .DESCENDING(1'b1)
    ) u_desc (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .data_valid_i(data_valid_i),
        .tdata_o(tdata_d), .tvalid_o(tvalid_d), .tready_i(tready_i),
        .tlast_o(tlast_d), .tindex_o(tindex_d), .fill_level_o(fill_d),
        .overflow_o(ovf_d), .clear_overflow_i(clear_overflow_i)
    );

    function automatic vec_t mk(int a, int b, int c, int d);
        vec_t v;
        v[0] = a[W-1:0];
        v[1] = b[W-1:0];
        v[2] = c[W-1:0];
        v[3] = d[W-1:0];
        return v;
    endfunction

    function automatic vec_t random_sorted_vec();
        vec_t v;
        int   acc = 0;
        for (int e = 0; e < N; e++) begin
            acc += int'($urandom_range(0, 63));
            v[e] = acc[W-1:0];
        end
        return v;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            beat_m[i] = 0;
            ovf_m[i]  = 1'b0;
        end
    endtask

    // Edge behaviour of a vector queue with beat counter; instance 0 holds 4, instance 1 holds 2.
    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            bit xfer, last, popv, acc;
            int depth;
            depth = (i == 0) ? 4 : 2;
            xfer  = (mq[i].size() != 0) && tready_i;
            last  = (beat_m[i] == N - 1);
            popv  = xfer && last;
            acc   = data_valid_i && ((mq[i].size() < depth) || popv);
            if (xfer) beat_m[i] = last ? 0 : beat_m[i] + 1;
            if (popv) void'(mq[i].pop_front());
            if (acc) mq[i].push_back(data_i);
            if (data_valid_i && !acc) ovf_m[i] = 1'b1;
            else if (clear_overflow_i) ovf_m[i] = 1'b0;
        end
    endtask

    task automatic check_all(input string step);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] ev, ei, ed, el, ef, eo;
            logic [31:0] ov, oi, od, ol, of, oo;
            string       nm;
            ev = (mq[i].size() != 0) ? 1 : 0;
            ei = ev ? ((i == 1) ? (N - 1 - beat_m[i]) : beat_m[i]) : 0;
            ed = ev ? 32'(mq[i][0][ei]) : 0;
            el = (ev && beat_m[i] == N - 1) ? 1 : 0;
            ef = mq[i].size();
            eo = 32'(ovf_m[i]);
            if (i == 0) begin
                nm = "asc";
                ov = 32'(tvalid_a); oi = 32'(tindex_a); od = 32'(tdata_a);
                ol = 32'(tlast_a);  of = 32'(fill_a);   oo = 32'(ovf_a);
            end else begin
                nm = "desc";
                ov = 32'(tvalid_d); oi = 32'(tindex_d); od = 32'(tdata_d);
                ol = 32'(tlast_d);  of = 32'(fill_d);   oo = 32'(ovf_d);
            end
            check_output($sformatf("%s/%s tvalid", step, nm), ov, ev);
            check_output($sformatf("%s/%s tindex", step, nm), oi, ei);
            check_output($sformatf("%s/%s tdata", step, nm), od, ed);
            check_output($sformatf("%s/%s tlast", step, nm), ol, el);
            check_output($sformatf("%s/%s fill", step, nm), of, ef);
            check_output($sformatf("%s/%s overflow", step, nm), oo, eo);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input vec_t vec, input logic ready,
                                  input logic clear, input string step);
        data_valid_i     = valid;
        data_i           = vec;
        tready_i         = ready;
        clear_overflow_i = clear;
        @(posedge clk_i);
        model_update();
        #1;
        check_all(step);
    endtask

    // Asserted between edges so the asynchronous path is what clears the outputs.
    task automatic do_reset(input string step);
        rst_i = 1'b1;
        #1;
        model_reset();
        check_all(step);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i            = 1'b0;
        data_i           = '0;
        data_valid_i     = 1'b0;
        tready_i         = 1'b0;
        clear_overflow_i = 1'b0;
        #2;
        do_reset("reset");

        apply_stimulus(1'b1, mk(1, 3, 7, 9), 1'b1, 1'b0, "single");
        repeat (5) apply_stimulus(1'b0, '0, 1'b1, 1'b0, "single_drain");

        apply_stimulus(1'b1, mk(1, 3, 7, 9), 1'b0, 1'b0, "backpressure");
        apply_stimulus(1'b1, mk(2, 4, 6, 8), 1'b1, 1'b0, "backpressure");
        for (int c = 0; c < 20; c++) apply_stimulus(1'b0, '0, c[0], 1'b0, "bp_drain");

        for (int k = 0; k < 3; k++)
            apply_stimulus(1'b1, mk(10 + k, 20 + k, 30 + k, 40 + k), 1'b0, 1'b0, "ovf_fill");
        repeat (14) apply_stimulus(1'b0, '0, 1'b1, 1'b0, "ovf_drain");
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, "ovf_clear");

        apply_stimulus(1'b1, mk(11, 12, 13, 14), 1'b0, 1'b0, "full");
        apply_stimulus(1'b1, mk(21, 22, 23, 24), 1'b0, 1'b0, "full");
        repeat (3) apply_stimulus(1'b0, '0, 1'b1, 1'b0, "full_beats");
        apply_stimulus(1'b1, mk(31, 32, 33, 34), 1'b1, 1'b0, "full_pop_write");
        apply_stimulus(1'b1, mk(41, 42, 43, 44), 1'b0, 1'b1, "drop_with_clear");
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, "clear_only");
        repeat (20) apply_stimulus(1'b0, '0, 1'b1, 1'b0, "full_drain");

        apply_stimulus(1'b1, mk(1, 3, 7, 9), 1'b1, 1'b0, "mid_reset");
        repeat (2) apply_stimulus(1'b0, '0, 1'b1, 1'b0, "mid_reset_beats");
        do_reset("mid_reset_async");
        apply_stimulus(1'b1, mk(5, 6, 7, 8), 1'b1, 1'b0, "after_reset");
        repeat (5) apply_stimulus(1'b0, '0, 1'b1, 1'b0, "after_reset_drain");

        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset("random_reset");
            apply_stimulus(($urandom % 3) != 0, random_sorted_vec(), ($urandom % 4) != 0,
                           ($urandom % 16) == 0, "random");
        end
        repeat (20) apply_stimulus(1'b0, '0, 1'b1, 1'b0, "final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sorted_vector_serializer.md
Name: sorted_vector_serializer

Overview:
- Downstream consumer of the pipelined sorting network.
- Accepts one fully sorted parallel vector per cycle on a valid-only interface; the sorter cannot be stalled.
- Buffers complete vectors in a small vector FIFO and emits them one element per beat on an AXI-Stream-style valid/ready output, with an end-of-vector marker and rank index.
- Drops and flags any vector that arrives with no free FIFO slot.

Parameters:
NUMBER_WIDTH, 10, bit width of each element (unsigned)
NUMBERS_AMOUNT, 10, elements per vector (>=1)
FIFO_DEPTH, 4, vectors buffered; power of two, >=2
DESCENDING, 0, 0: emit index 0 (smallest) first; 1: emit index NUMBERS_AMOUNT-1 (largest) first

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
data_i  input  NUMBERS_AMOUNT x NUMBER_WIDTH  sorted vector, element 0 = smallest
data_valid_i  input  1  data_i valid this cycle (single-cycle qualifier, no ready)
tdata_o  output  NUMBER_WIDTH  current element
tvalid_o  output  1  tdata_o/tlast_o/tindex_o valid
tready_i  input  1  downstream accepts beat
tlast_o  output  1  last element of current vector
tindex_o  output  max(1,$clog2(NUMBERS_AMOUNT))  input index of element on tdata_o
fill_level_o  output  $clog2(FIFO_DEPTH+1)  vectors currently stored, including the one being emitted
overflow_o  output  1  sticky: a vector was dropped
clear_overflow_i  input  1  synchronous clear of overflow_o

Behaviour:
- Reset (async assert, state change on rst_i rising edge):
  - FIFO empty; beat counter 0.
  - All outputs 0: tvalid_o, tlast_o, tdata_o, tindex_o, fill_level_o, overflow_o.
  - Reset mid-vector discards the partial vector; no tlast_o is produced for it.
- Beat handshake: a beat transfers on a rising edge with tvalid_o && tready_i.
- Write rule:
  - On an edge with data_valid_i=1, the vector is written if fill_level < FIFO_DEPTH, or if this same edge transfers the tlast beat (the pop frees a slot).
  - Otherwise the vector is dropped whole (never partially stored) and overflow_o <= 1.
- fill_level_o update per edge: +1 on write only, -1 on pop only, unchanged on write+pop.
- Latency: vector written at edge k; tvalid_o=1 from edge k onward, provided the FIFO was empty before edge k. No combinational path from data_i/data_valid_i to any output.
- Output stage:
  - tvalid_o = (fill_level != 0).
  - Head vector and beat counter b (0..NUMBERS_AMOUNT-1) select the element: tindex_o = b if DESCENDING=0, else NUMBERS_AMOUNT-1-b; tdata_o = head[tindex_o].
  - tlast_o = tvalid_o && (b == NUMBERS_AMOUNT-1).
  - On a transfer: b increments; on the tlast transfer, b wraps to 0 and the head vector is popped.
- Stability: while tvalid_o && !tready_i, tdata_o, tindex_o and tlast_o hold constant. tvalid_o never deasserts without a transfer, except on reset.
- NUMBERS_AMOUNT=1: every beat has tlast_o=1 and tindex_o=0.
- Pointers: read/write pointers wrap modulo FIFO_DEPTH. Full vs. empty is distinguished by fill_level, not by pointer equality.
- overflow_o: set and clear_overflow_i on the same edge → set wins (overflow_o=1). Otherwise clear_overflow_i=1 → 0.
- Arithmetic: elements pass through bit-exact. No comparison or reordering beyond the DESCENDING index mapping.

Test Plan:
1. W=8, N=4, DEPTH=4, tready_i=1; one vector {1,3,7,9} (index 0..3) at edge 0 → beats at edges 1..4: tdata 1,3,7,9; tindex 0,1,2,3; tlast only on 9; fill_level 1→0 after edge 4.
2. Same stimulus with DESCENDING=1 → tdata 9,7,3,1; tindex 3,2,1,0; tlast on 1.
3. Backpressure: tready_i toggling 0/1 every cycle, two back-to-back vectors {1,3,7,9},{2,4,6,8} → eight beats in order 1,3,7,9,2,4,6,8. Outputs stable during every stalled cycle; two tlast pulses.
4. Overflow: DEPTH=2, tready_i=0, three vectors on consecutive cycles → fill_level 2, overflow_o=1 after the third. Release tready_i → exactly 8 beats from the first two vectors. Pulse clear_overflow_i → overflow_o=0.
5. Full FIFO (DEPTH=2); data_valid_i on the same edge as the tlast transfer → vector accepted, fill_level stays 2, overflow_o stays 0. Also assert clear_overflow_i on an edge with a drop → overflow_o=1.
6. Reset mid-vector after 2 of 4 beats → tvalid_o=0 and fill_level_o=0 immediately, no tlast. Next vector {5,6,7,8} emits from tindex 0.
